// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice roller block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        DONE
    } state_t;

    typedef logic [2:0] die_t;

    // Feedback taps of the 16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1).
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Fold a 3-bit random field onto a die face 1..6; raw 6 and 7 wrap to 1 and 2.
    function automatic die_t die_map(input logic [2:0] raw);
        die_t face;
        if (raw >= 3'd6) begin
            face = raw - 3'd5;
        end else begin
            face = raw + 3'd1;
        end
        return face;
    endfunction

endpackage

// File: rtl/dice_roller_if.sv
// Request/result bundle between the game controller and the dice roller.
// Latency: n/a (wiring only); master drives requests, slave drives results.
// Backpressure: none; results are level outputs plus a one-cycle done pulse.
// Signals: roll_req/fast_fwd (controller -> roller), d1/d2/rolling/done (roller -> controller).
interface dice_roller_if;
    import dice_pkg::*;

    logic roll_req;
    logic fast_fwd;
    die_t d1;
    die_t d2;
    logic rolling;
    logic done;

    modport master (
        output roll_req,
        output fast_fwd,
        input  d1,
        input  d2,
        input  rolling,
        input  done
    );

    modport slave (
        input  roll_req,
        input  fast_fwd,
        output d1,
        output d2,
        output rolling,
        output done
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, stepped every clock from reset.
// Latency: state is registered; a new value every clock.
// Backpressure: none; it never stalls.
// Ports: clk, resetn (async active-low), state (current 16-bit LFSR value).
module lfsr16
    import dice_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] state
);

    // The all-zero state is a lock-up point for this LFSR, so a zero seed is replaced.
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= INIT;
        end else if (state[0]) begin
            state <= (state >> 1) ^ LFSR_MASK;
        end else begin
            state <= state >> 1;
        end
    end

endmodule

// File: rtl/dice_roller.sv
// Dice roller: button-triggered shuffle animation that latches two die values and pulses done.
// Latency: ROLL starts 3 clocks after roll_req rises; roll lasts ROLL_TICKS*TICK_DIV clocks (1 with fast_fwd).
// Backpressure: none; requests arriving during ROLL or DONE are dropped, not queued.
// Ports: clk, resetn (async active-low), bus (slave side: roll_req, fast_fwd in; d1, d2, rolling, done out).
module dice_roller
    import dice_pkg::*;
#(
    parameter int          TICK_DIV   = 2_500_000,
    parameter int          ROLL_TICKS = 16,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic         clk,
    input  logic         resetn,
    dice_roller_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (ROLL_TICKS > 1) ? $clog2(ROLL_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] ROLL_LAST = RW'(ROLL_TICKS - 1);

    logic [15:0]   lfsr;
    logic          sync1;
    logic          sync2;
    logic          prev;
    logic          req_edge;
    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [RW-1:0] roll_cnt;
    die_t          d1_q;
    die_t          d2_q;
    logic          rolling_q;
    logic          done_q;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk   (clk),
        .resetn(resetn),
        .state (lfsr)
    );

    // Only the low six bits feed the dice; the rest exist for the sequence period.
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr[15:6];

    // Two-flop synchronizer on the raw button, plus a delayed copy for rising-edge detect.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= bus.roll_req;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign req_edge = sync2 & ~prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            roll_cnt  <= '0;
            d1_q      <= 3'd1;
            d2_q      <= 3'd1;
            rolling_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_edge) begin
                        state     <= ROLL;
                        tick_cnt  <= '0;
                        roll_cnt  <= '0;
                        rolling_q <= 1'b1;
                    end
                end
                ROLL: begin
                    // fast_fwd wins over a coincident tick; both take the same sample.
                    if (bus.fast_fwd) begin
                        d1_q      <= die_map(lfsr[2:0]);
                        d2_q      <= die_map(lfsr[5:3]);
                        state     <= DONE;
                        rolling_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        d1_q     <= die_map(lfsr[2:0]);
                        d2_q     <= die_map(lfsr[5:3]);
                        if (roll_cnt == ROLL_LAST) begin
                            state     <= DONE;
                            rolling_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            roll_cnt <= roll_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Any edge seen in this cycle is deliberately lost.
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    rolling_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d1      = d1_q;
    assign bus.d2      = d2_q;
    assign bus.rolling = rolling_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: LFSR reset sequence, table of roll scenarios, mid-roll reset, zero seed.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_dice_roller;

    localparam int          TD   = 4;
    localparam int          RT   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic [15:0] lfsr;
        logic [2:0]  d1;
        logic [2:0]  d2;
        logic        rolling;
        logic        done;
    } lfsr_vec_t;

    typedef struct {
        int ff_at;       // ROLL cycle index where fast_fwd is raised, -1 for none
        int toggle;      // toggle roll_req during the roll
        int rereq_at;    // drop roll_req at ROLL start, re-raise at this index, -1 for none
        int exp_len;     // expected number of cycles with rolling=1
        int exp_restart; // a second roll should start 2 cycles after DONE
    } roll_vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rst2_n;
    logic [15:0] m_lfsr;
    logic [2:0]  exp_d1;
    logic [2:0]  exp_d2;
    int          n_tests = 0;
    int          n_fail  = 0;

    lfsr_vec_t lv[5];
    roll_vec_t rv[8];

    always #5 clk = ~clk;

    dice_roller_if bus ();
    dice_roller_if bus2 ();

    dice_roller #(.TICK_DIV(TD), .ROLL_TICKS(RT), .SEED(SEED)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    dice_roller #(.TICK_DIV(TD), .ROLL_TICKS(RT), .SEED(16'h0000)) dut0 (
        .clk   (clk),
        .resetn(rst2_n),
        .bus   (bus2)
    );

    function automatic logic [15:0] ref_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic [2:0] ref_die(input logic [2:0] v);
        int n;
        n = (int'(v) % 6) + 1;
        return 3'(n);
    endfunction

    // Reference LFSR: value of the design's LFSR in the current cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_lfsr <= SEED;
        else         m_lfsr <= ref_step(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dice(input string tag);
        check({tag, "_d1"}, bus.d1, exp_d1);
        check({tag, "_d2"}, bus.d2, exp_d2);
        check({tag, "_range"}, (bus.d1 >= 3'd1 && bus.d1 <= 3'd6 && bus.d2 >= 3'd1 && bus.d2 <= 3'd6), 1);
    endtask

    task automatic run_roll(input roll_vec_t v, input int idx);
        logic [15:0] lf;
        int          r;
        bit          finished;
        bit          smp;
        bit          fin;
        string       tag;
        tag = $sformatf("roll%0d", idx);
        bus.roll_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("%s_start%0d", tag, i), bus.rolling, (i == 3) ? 1 : 0);
        end
        r = 0;
        finished = 1'b0;
        while (!finished && r < 64) begin
            if (v.ff_at >= 0 && r >= v.ff_at) bus.fast_fwd = 1'b1;
            if (v.toggle != 0) bus.roll_req = (r < 6) ? r[0] : 1'b0;
            if (v.rereq_at >= 0) bus.roll_req = (r >= v.rereq_at);
            lf  = m_lfsr;
            fin = (v.ff_at >= 0 && r >= v.ff_at) || (r == RT * TD - 1);
            smp = fin || ((r % TD) == TD - 1);
            step();
            if (smp) begin
                exp_d1 = ref_die(lf[2:0]);
                exp_d2 = ref_die(lf[5:3]);
            end
            check_dice($sformatf("%s_r%0d", tag, r));
            if (fin) begin
                check({tag, "_done"}, bus.done, 1);
                check({tag, "_rolling_end"}, bus.rolling, 0);
                check({tag, "_len"}, r + 1, v.exp_len);
                finished = 1'b1;
            end else begin
                check($sformatf("%s_busy%0d", tag, r), {bus.rolling, bus.done}, 2'b10);
            end
            r++;
        end
        if (!finished) check({tag, "_timeout"}, 0, 1);
        step();
        check({tag, "_idle1"}, {bus.rolling, bus.done}, 2'b00);
        check_dice({tag, "_hold1"});
        lf = m_lfsr;
        step();
        check({tag, "_restart"}, bus.rolling, v.exp_restart);
        check({tag, "_idle2_done"}, bus.done, 0);
        if (v.exp_restart != 0) begin
            // fast_fwd is still high, so the restarted roll ends after one cycle
            lf = m_lfsr;
            step();
            exp_d1 = ref_die(lf[2:0]);
            exp_d2 = ref_die(lf[5:3]);
            check({tag, "_re_done"}, bus.done, 1);
            check_dice({tag, "_re"});
        end
        bus.fast_fwd = 1'b0;
        bus.roll_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("%s_quiet%0d", tag, i), {bus.rolling, bus.done}, 2'b00);
        end
        check_dice({tag, "_quiet"});
    endtask

    task automatic reset_mid_roll();
        bus.roll_req = 1'b1;
        for (int i = 0; i < 3 + 5; i++) step();
        check("mr_in_roll", bus.rolling, 1);
        bus.roll_req = 1'b0;
        resetn = 1'b0;
        #1;
        exp_d1 = 3'd1;
        exp_d2 = 3'd1;
        check_dice("mr_rst");
        check("mr_rst_flags", {bus.rolling, bus.done}, 2'b00);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("mr_hold%0d", i), {bus.rolling, bus.done}, 2'b00);
        end
        resetn = 1'b1;
        check("mr_lfsr0", dut.lfsr, 16'hACE1);
        step();
        check("mr_lfsr1", dut.lfsr, 16'hE270);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mr_after%0d", i), {bus.rolling, bus.done}, 2'b00);
        end
        check_dice("mr_after");
    endtask

    task automatic seed0_check();
        int period;
        bit zero_seen;
        period    = 0;
        zero_seen = 1'b0;
        check("seed0_init", dut0.lfsr, 16'h0001);
        for (int i = 1; i <= 70000; i++) begin
            @(posedge clk);
            #1;
            if (dut0.lfsr == 16'h0000) zero_seen = 1'b1;
            if (period == 0 && dut0.lfsr == 16'h0001) period = i;
        end
        check("seed0_never_zero", zero_seen, 0);
        check("seed0_period", period, 65535);
    endtask

    initial begin
        lv[0] = '{16'hACE1, 3'd1, 3'd1, 1'b0, 1'b0};
        lv[1] = '{16'hE270, 3'd1, 3'd1, 1'b0, 1'b0};
        lv[2] = '{16'h7138, 3'd1, 3'd1, 1'b0, 1'b0};
        lv[3] = '{16'h389C, 3'd1, 3'd1, 1'b0, 1'b0};
        lv[4] = '{16'h1C4E, 3'd1, 3'd1, 1'b0, 1'b0};
        //          ff  tog rereq len restart
        rv[0] = '{-1, 0, -1, 12, 0};  // full roll
        rv[1] = '{ 2, 0, -1,  3, 0};  // fast_fwd two cycles in
        rv[2] = '{ 0, 0, -1,  1, 0};  // fast_fwd in first ROLL cycle
        rv[3] = '{ 3, 0, -1,  4, 0};  // fast_fwd on first tick
        rv[4] = '{ 7, 0, -1,  8, 0};  // fast_fwd on second tick
        rv[5] = '{-1, 1, -1, 12, 0};  // toggling request during ROLL
        rv[6] = '{ 2, 0,  1,  3, 0};  // edge lands in DONE cycle: dropped
        rv[7] = '{ 2, 0,  2,  3, 1};  // edge lands one cycle later: accepted

        bus.roll_req  = 1'b0;
        bus.fast_fwd  = 1'b0;
        bus2.roll_req = 1'b0;
        bus2.fast_fwd = 1'b0;
        exp_d1 = 3'd1;
        exp_d2 = 3'd1;
        resetn = 1'b0;
        rst2_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lfsr", dut.lfsr, SEED);
        check("rst_flags", {bus.rolling, bus.done}, 2'b00);
        check_dice("rst");
        resetn = 1'b1;
        rst2_n = 1'b1;

        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) step();
                    check($sformatf("lfsr%0d", i), dut.lfsr, lv[i].lfsr);
                    check($sformatf("lfsr%0d_d1", i), bus.d1, lv[i].d1);
                    check($sformatf("lfsr%0d_d2", i), bus.d2, lv[i].d2);
                    check($sformatf("lfsr%0d_rolling", i), bus.rolling, lv[i].rolling);
                    check($sformatf("lfsr%0d_done", i), bus.done, lv[i].done);
                end
                for (int i = 0; i < 5; i++) step();
                for (int i = 0; i < 8; i++) run_roll(rv[i], i);
                reset_mid_roll();
                run_roll(rv[1], 8);
            end
            begin
                seed0_check();
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
- Upstream stage of the game control path. Produces the two die values d1/d2 (1..6) that the turn FSM consumes to compute move distance.
- On a roll request it runs a short shuffle animation: the displayed dice change at a slow tick rate. It then latches final values and pulses done.
- Randomness comes from a free-running 16-bit Galois LFSR stepped every clock from reset, so human press timing provides entropy.

Parameters:
- TICK_DIV, 2_500_000, clocks per shuffle tick (20 Hz at 50 MHz); minimum 2.
- ROLL_TICKS, 16, shuffle ticks per roll including the final sample; minimum 1.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- roll_req  in  1  asynchronous button level (active-high), synchronized internally
- fast_fwd  in  1  level; when high in ROLL, the roll finishes on the next clock
- d1  out  3  die 1 value, 1..6
- d2  out  3  die 2 value, 1..6
- rolling  out  1  high while in ROLL
- done  out  1  one-cycle pulse when the final values are stable on d1/d2

Behaviour:
- Reset (async, resetn=0):
  - lfsr=SEED (or 1 if SEED is 0); d1=1, d2=1; rolling=0, done=0.
  - State IDLE; tick counter and roll counter 0; sync flops 0.
- LFSR:
  - Steps every clock in every state.
  - If lfsr[0]=1, next = (lfsr>>1)^16'hB400; otherwise next = lfsr>>1.
  - It never reaches 0.
- Sampling: "sample" means d1 <= (lfsr[2:0] mod 6)+1 and d2 <= (lfsr[5:3] mod 6)+1, using the current lfsr value. Values 6 and 7 map to 1 and 2; this bias is accepted.
- Request path:
  - roll_req passes through 2 flops, then a registered previous-value flop.
  - The edge is sync & ~prev.
  - ROLL is entered on the clock after the edge, i.e. 3 clocks after roll_req rises at the input.
- IDLE:
  - d1/d2 hold their values.
  - On an edge: go to ROLL, clear the tick counter and roll counter.
- ROLL:
  - rolling=1. The tick counter counts 0..TICK_DIV-1 and wraps.
  - At a wrap (counter==TICK_DIV-1), sample and increment the roll counter.
  - When a wrap occurs with roll counter==ROLL_TICKS-1, sample and go to DONE.
  - If fast_fwd=1 in any ROLL cycle, sample and go to DONE that cycle. fast_fwd has priority over a coincident tick.
  - Roll-request edges during ROLL or DONE are ignored; they are neither queued nor restart the roll.
- DONE:
  - Lasts exactly one cycle: done=1, rolling=0, d1/d2 hold. Then go to IDLE.
  - An edge arriving in the DONE cycle is dropped. An edge in the following IDLE cycle is accepted.
- Outputs: all registered, with no combinational path from inputs.
- Timing: total ROLL duration is ROLL_TICKS*TICK_DIV cycles without fast_fwd.
- Reset mid-roll returns immediately to the reset values above, with no done pulse.
- Counter widths: $clog2 of TICK_DIV and of ROLL_TICKS respectively, using a minimum width of 1.

Decomposition:
- Package dice_pkg:
  - state enum {IDLE, ROLL, DONE}
  - LFSR_MASK = 16'hB400
  - function die_map(3-bit) returning 1..6
- Sub-module lfsr16:
  - Ports: clk, resetn, seed parameter, 16-bit state output.
  - Free-running, steps every clock.
- dice_roller holds the synchronizer, FSM, counters and output registers.

Test Plan:
- LFSR: reset with SEED=16'hACE1; check lfsr=ACE1, then E270 after 1 clock, then 7138 after 2. d1=d2=1, rolling=0, done=0 throughout.
- Full roll (TICK_DIV=4, ROLL_TICKS=3): raise roll_req at cycle 10 and hold.
  - rolling rises at cycle 13.
  - d1/d2 change only at ticks 16, 20 and 24.
  - done pulses at cycle 25 for one cycle.
  - Final d1/d2 match a model of die_map(lfsr) at cycle 24.
  - d1/d2 always stay within 1..6.
- Fast forward: raise fast_fwd 2 cycles into ROLL. The next cycle is DONE (done=1) and values equal the sample from the fast_fwd cycle. The remaining ticks are skipped.
- Ignored requests:
  - Toggling roll_req during ROLL: exactly one done per roll, duration unchanged.
  - An edge in the DONE cycle is dropped.
  - An edge one cycle later starts a new roll.
- Reset mid-roll: assert resetn=0 at tick 2 of a roll. Outputs return immediately to d1=d2=1, rolling=0 with no done pulse. After release, the LFSR restarts at SEED.
- SEED=0 variant: the LFSR starts at 0001 and never becomes 0 over 70000 clocks; its period is 65535.
